// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds the op/state encodings plus the fixed-latency and special-case result constants.
package mdu_pkg;
    localparam int MDU_WIDTH = 17;
    localparam int MDU_AW    = 4;
    localparam int MDU_LAT   = 20;

    localparam logic [MDU_WIDTH-1:0] DIV0_Q   = 17'h1FFFF;
    localparam logic [MDU_WIDTH-1:0] MOST_NEG = 17'h10000;

    typedef enum logic [1:0] {
        MDU_MUL  = 2'b00,
        MDU_MULH = 2'b01,
        MDU_DIV  = 2'b10,
        MDU_REM  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } mdu_state_e;
endpackage

// File: rtl/mdu_shift_core.sv
// Unsigned shift-add / restoring shift-subtract engine on operand magnitudes.
// Divider step is only built when MDU_DIV_EN is defined.
module mdu_shift_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   mag_a,
    input  logic [WIDTH-1:0]   mag_b,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);
    logic [WIDTH-1:0]   divisor;
    logic [4:0]         cnt;
    logic [WIDTH-1:0]   hi, lo, addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_next, acc_next;
`ifdef MDU_DIV_EN
    logic [WIDTH:0]     shifted, diff;
    logic [2*WIDTH-1:0] div_next;
`endif

    assign hi   = acc[2*WIDTH-1:WIDTH];
    assign lo   = acc[WIDTH-1:0];
    assign last = (cnt == 5'(WIDTH-1));

    always_comb begin
        addend   = lo[0] ? divisor : '0;
        sum      = {1'b0, hi} + {1'b0, addend};
        mul_next = {sum, lo[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        // remainder stays below the divisor, so the shifted value never needs bit WIDTH
        shifted  = {hi, lo[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        div_next = diff[WIDTH] ? {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
        acc_next = is_div ? div_next : mul_next;
`else
        acc_next = is_div ? acc : mul_next;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            divisor <= '0;
            cnt     <= '0;
        end else if (load) begin
            acc     <= {{WIDTH{1'b0}}, mag_a};
            divisor <= mag_b;
            cnt     <= '0;
        end else if (step) begin
            acc <= acc_next;
            if (!last) cnt <= cnt + 5'd1;
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// Fixed-latency (20 cycle) signed multiply/divide unit writing back to the register file.
// Define MDU_DIV_EN to build the divider; otherwise DIV/REM pulse done with no write.
//
// state | meaning
// IDLE  | waiting for start
// PREP  | latch signs, magnitudes and special-case flags
// RUN   | WIDTH shift steps in the core
// FIX   | apply signs, pick output word
// DONE  | one-cycle write pulse
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int AW    = MDU_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    dst_addr_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [AW-1:0]    dst_addr,
    output logic             we
);
    mdu_state_e         state;
    mdu_op_e            op_q;
    logic [WIDTH-1:0]   a_q, b_q, mag_a, mag_b, result_q, fix_result;
    logic [AW-1:0]      dst_addr_q;
    logic               neg_q, done_q, we_q, fix_we, last;
    logic [2*WIDTH-1:0] acc, prod;
`ifdef MDU_DIV_EN
    logic               sa_q, div0_q, ovf_q;
    logic [WIDTH-1:0]   quo, rem;
`endif

    assign mag_a = a_q[WIDTH-1] ? -a_q : a_q;
    assign mag_b = b_q[WIDTH-1] ? -b_q : b_q;

    mdu_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (state == PREP),
        .step   (state == RUN),
        .is_div (op_q[1]),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .acc    (acc),
        .last   (last)
    );

    always_comb begin
        prod       = neg_q ? -acc : acc;
        fix_result = '0;
        fix_we     = 1'b1;
`ifdef MDU_DIV_EN
        quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif
        case (op_q)
            MDU_MUL:  fix_result = prod[WIDTH-1:0];
            MDU_MULH: fix_result = prod[2*WIDTH-1:WIDTH];
`ifdef MDU_DIV_EN
            MDU_DIV:  fix_result = div0_q ? DIV0_Q : (ovf_q ? a_q : quo);
            default:  fix_result = div0_q ? a_q : (ovf_q ? '0 : rem);
`else
            default:  fix_we = 1'b0;
`endif
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= MDU_MUL;
            a_q        <= '0;
            b_q        <= '0;
            dst_addr_q <= '0;
            result_q   <= '0;
            neg_q      <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
`ifdef MDU_DIV_EN
            sa_q       <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            if (flush && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        op_q       <= mdu_op_e'(op);
                        a_q        <= a;
                        b_q        <= b;
                        dst_addr_q <= dst_addr_in;
                        state      <= PREP;
                    end
                    PREP: begin
                        neg_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
`ifdef MDU_DIV_EN
                        sa_q   <= a_q[WIDTH-1];
                        div0_q <= (b_q == '0);
                        ovf_q  <= (a_q == MOST_NEG) && (b_q == '1);
`endif
                        state  <= RUN;
                    end
                    RUN: if (last) state <= FIX;
                    FIX: begin
                        result_q <= fix_result;
                        done_q   <= 1'b1;
                        we_q     <= fix_we;
                        state    <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // flush during DONE must cancel the write in the same cycle
    assign busy     = (state != IDLE);
    assign done     = done_q & ~flush;
    assign we       = we_q & ~flush;
    assign result   = result_q;
    assign dst_addr = dst_addr_q;
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multi-cycle multiply/divide unit for the 17-bit datapath, directly downstream of the register file read ports. Operands come straight from rf p0/p1; the result goes back on the rf write port (dst, dst_addr, we) as a single-cycle write pulse. Latency is fixed, so hazard logic can count cycles instead of snooping state.

## Interface
- WIDTH, 17, data width; must match the register file word.
- AW, 4, register address width.
- clk  in  1  clock; all flops on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- op  in  2  00 MUL (low word), 01 MULH (signed high word), 10 DIV (signed quotient), 11 REM (signed remainder).
- a  in  WIDTH  operand A / dividend (rf p0).
- b  in  WIDTH  operand B / divisor (rf p1).
- dst_addr_in  in  AW  destination register, captured with start.
- flush  in  1  abort the in-flight operation.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  result, valid only while done.
- dst_addr  out  AW  captured destination.
- we  out  1  rf write enable; equals done.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: start=1 captures op, a, b, dst_addr_in, then goes to PREP. start while busy is ignored, not queued.
- PREP (1 cycle):
  - Record operand signs.
  - Take absolute values.
  - Flag divide-by-zero (b==0) and overflow (a==17'h10000 and b==17'h1FFFF, DIV/REM only).
- RUN (exactly WIDTH cycles, 5-bit counter 0..WIDTH-1):
  - MUL/MULH: shift-add into a 2*WIDTH accumulator.
  - DIV/REM: restoring shift-subtract.
- FIX (1 cycle): apply signs and select the output word.
  - MUL: product[16:0]. MULH: product[33:17] of the signed 34-bit product.
  - DIV: quotient truncates toward zero. REM: remainder takes the sign of the dividend.
  - Divide by zero: quotient 17'h1FFFF, remainder = a.
  - Overflow: quotient = a, remainder 0.
- DONE (1 cycle): done=we=1, result valid. Next state is IDLE.
- flush in any non-IDLE state: next state IDLE and no write. flush in the DONE cycle forces done/we to 0 combinationally.
- Reset: state IDLE, busy=0, done=0, we=0, result=0, dst_addr=0, counter=0. Reset mid-operation discards the operation.

## Timing
- start sampled at edge E0. State is PREP in cycle 1, RUN in cycles 2..18, FIX in cycle 19, DONE in cycle 20.
- done asserts WIDTH+3 = 20 cycles after the start cycle, independent of op and operands, including divide-by-zero and overflow.
- busy is high in cycles 1..20. Earliest next accepted start is cycle 21 (back-to-back issue period: 21 cycles).
- result, dst_addr and we are registered outputs; no combinational path from inputs except flush→done/we.

## Configuration
- MDU_DIV_EN defined: the full divider is built as described.
- MDU_DIV_EN undefined:
  - Divider hardware is removed.
  - DIV/REM are still accepted with the same 20-cycle latency.
  - They complete with result 0 and we=0 (no register write); done still pulses.
  - MUL/MULH are unaffected.

## Structure
- Package mdu_pkg holds:
  - op enum (MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM);
  - state enum;
  - WIDTH/AW defaults;
  - constants MDU_LAT=20, DIV0_Q=17'h1FFFF, MOST_NEG=17'h10000.
- One sub-module, mdu_shift_core, holds the accumulator, counter and add/sub step. The top holds the FSM, sign handling, flush and output registers.

## Test plan
- MUL a=3, b=5, dst_addr_in=4'h7: done/we high exactly in cycle 20, result 17'h0000F, dst_addr 4'h7; busy high in cycles 1..20.
- MULH and MUL with a=17'h10000, b=2: MULH result 17'h1FFFF, MUL result 17'h00000.
- DIV/REM a=-7 (17'h1FFF9), b=2: quotient 17'h1FFFD (-3), remainder 17'h1FFFF (-1). Same test with MDU_DIV_EN undefined: done pulses with result 0 and we=0.
- Boundary cases:
  - DIV 5/0: result 17'h1FFFF. REM 5/0: result 5.
  - DIV 17'h10000/17'h1FFFF: result 17'h10000. REM of the same operands: result 0.
- start re-asserted with different operands in cycle 5: ignored, first result unchanged. flush in cycle 10: no done, IDLE in cycle 11.
- rst asserted asynchronously mid-RUN: all outputs 0 immediately. A new MUL issued after release completes in 20 cycles with the correct result.
